pixel_overlay_mixer_pipe: RTL
=============================

Name: pixel_overlay_mixer_pipe

Overview:
- Pipelined, parametrised overlay mixer between the camera frame path and the VGA output; successor to the combinational overlay mixer.
- Draws, over the camera pixel: centre reticle, target aim cross, target bounding box and a lock-status icon.
- Target data is latched once per frame so overlays never tear mid-frame.
- Lock-on uses a frame-counted hysteresis FSM (acquire/hold) instead of a per-pixel instantaneous test. The lock icon blinks while lock is being held without the target.

Parameters:
- CX, 320, reticle centre X.
- CY, 240, reticle centre Y.
- LOCK_ZONE, 30, lock window half-size in pixels (strict inequality).
- LOCK_FRAMES, 4, consecutive in-zone frames needed to lock (≥1).
- UNLOCK_FRAMES, 8, consecutive out-of-zone frames before lock drops (≥1).
- BLINK_FRAMES, 8, frames per blink half-period in HOLD.
- THK, 1, aim-cross half-thickness.
- LEN, 10, aim-cross half-length.
- UI_X, 580, lock icon box left edge.
- UI_Y, 30, lock icon box top edge.
- SYNC_ACTIVE_LOW, 1, polarity of hsync/vsync in and out.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- de_in  in  1  active-video flag aligned to x_pixel/y_pixel/img_bg
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync
- x_pixel  in  10  current pixel X
- y_pixel  in  10  current pixel Y
- img_bg  in  12  camera RGB444
- aim_x  in  10  tracker centroid X
- aim_y  in  10  tracker centroid Y
- aim_detected  in  1  tracker valid
- box_x_min  in  10  bounding box left
- box_x_max  in  10  bounding box right
- box_y_min  in  10  bounding box top
- box_y_max  in  10  bounding box bottom
- overlay_en  in  1  0 = camera passthrough
- r_port  out  4  red
- g_port  out  4  green
- b_port  out  4  blue
- de_out  out  1  de_in delayed 2
- hsync_out  out  1  hsync_in delayed 2
- vsync_out  out  1  vsync_in delayed 2
- locked  out  1  1 in LOCKED or HOLD
- lock_state  out  2  SEARCH=0, ACQUIRE=1, LOCKED=2, HOLD=3

Behaviour:
- Reset (async assert, sync release):
  - rgb = 0, de_out = 0, hsync_out/vsync_out = inactive level.
  - locked = 0, lock_state = SEARCH.
  - Shadow target registers = 0 with detected = 0; frame and blink counters = 0.
  - Reset mid-frame discards the pipeline. Rendering restarts on the next pixel; the FSM restarts at the next frame tick.
- Frame tick:
  - Single-cycle pulse when vsync_in transitions into its active level (edge detected against a registered copy).
  - On the tick: shadow regs capture aim_x, aim_y, aim_detected and the box inputs; the FSM steps once.
  - Rendering uses only the shadow values.
- in_zone: aim_detected && |aim_x−CX| < LOCK_ZONE && |aim_y−CY| < LOCK_ZONE, evaluated on live inputs at the tick.
- FSM transitions, at tick only; cnt is a frame counter:
  - SEARCH: in_zone → ACQUIRE with cnt=1, or → LOCKED directly if LOCK_FRAMES=1.
  - ACQUIRE: !in_zone → SEARCH. Else cnt+1 == LOCK_FRAMES → LOCKED; otherwise cnt+1.
  - LOCKED: !in_zone → HOLD with cnt=1, or → SEARCH if UNLOCK_FRAMES=1.
  - HOLD: in_zone → LOCKED. Else cnt+1 == UNLOCK_FRAMES → SEARCH; otherwise cnt+1.
- Blink: free-running frame counter. blink_on toggles every BLINK_FRAMES ticks. It is reset to on at entry to HOLD.
- Pipeline, total latency 2 cycles for rgb, de, hsync, vsync:
  - Stage 1 registers coordinates, de, syncs and img_bg, plus per-layer hit flags.
  - Stage 2 registers the priority-muxed colour.
- Geometry (all signed 12-bit, so aim_x−LEN near 0 never wraps):
  - UI box: 30×30 at (UI_X, UI_Y).
  - Icon: 8×8 target bitmap (rows 3C,42,99,A5,A5,99,42,3C), scaled ×2, offset 7 inside the box.
  - Reticle: filled disc with dx²+dy² ≤ 36. Arms 2 px wide at distance 12..22. Corner brackets with one of dx/dy in 33..35 and the other in 20..35.
  - Aim cross: |y−aim_y| ≤ THK with |x−aim_x| ≤ LEN, or the same with x and y swapped.
  - Box: 1 px outline on the min/max rows and columns.
  - Aim cross and box are drawn only if shadow detected = 1.
- Colour priority, highest first:
  1. UI icon pixel → 000.
  2. UI background → FF0 in LOCKED; FF0/FFF per blink_on in HOLD; FFF otherwise.
  3. Reticle → 000.
  4. Aim cross → F00.
  5. Box → 0F0.
  6. img_bg.
- overlay_en = 0 → img_bg only; latency unchanged; FSM still runs.
- Stage-2 de = 0 → rgb forced to 000.

Test Plan:
- Reset held, random inputs → rgb 000, de_out 0, syncs inactive, lock_state 0. Release, de_in=1, x=5, y=5, img_bg=ABC → rgb ABC two cycles later.
- Target at (325,245), detected, for 4 frames → lock_state 0→1→1→1→2 across ticks, locked=1 after the 4th tick. Pixel (590,35) outside icon → FF0.
- From LOCKED, move target to (100,100) → HOLD at next tick, UI alternates FF0/FFF every 8 frames. After 8 out-of-zone ticks → SEARCH, UI FFF.
- Change aim_x mid-frame (200→300) → aim cross stays at x=200 until the next vsync tick, then moves.
- Aim at (3,3) with LEN=10 → cross drawn from x=0..13 and y=0..13. No pixels at x≈1020 from wrap.
- Overlapping layers: pixel (320,240) with the aim there → 000 (reticle beats aim). overlay_en=0 → img_bg. de_in=0 → 000.

Source files
------------

// File: rtl/pixel_overlay_mixer_pipe.sv
// pixel_overlay_mixer_pipe: two-stage overlay mixer (reticle, aim cross, box, lock icon) over camera video,
// with frame-latched target data and an acquire/hold lock FSM stepped once per frame.
module pixel_overlay_mixer_pipe #(
  parameter int CX = 320,
  parameter int CY = 240,
  parameter int LOCK_ZONE = 30,
  parameter int LOCK_FRAMES = 4,
  parameter int UNLOCK_FRAMES = 8,
  parameter int BLINK_FRAMES = 8,
  parameter int THK = 1,
  parameter int LEN = 10,
  parameter int UI_X = 580,
  parameter int UI_Y = 30,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic [11:0] img_bg,
  input  logic [9:0] aim_x,
  input  logic [9:0] aim_y,
  input  logic       aim_detected,
  input  logic [9:0] box_x_min,
  input  logic [9:0] box_x_max,
  input  logic [9:0] box_y_min,
  input  logic [9:0] box_y_max,
  input  logic       overlay_en,
  output logic [3:0] r_port,
  output logic [3:0] g_port,
  output logic [3:0] b_port,
  output logic       de_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       locked,
  output logic [1:0] lock_state
);
  localparam int CMAX = LOCK_FRAMES > UNLOCK_FRAMES ? LOCK_FRAMES : UNLOCK_FRAMES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic INACT = SYNC_ACTIVE_LOW != 0;
  localparam logic [63:0] ICON = 64'h3C42_99A5_A599_423C;
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED, HOLD} state_t;
  function automatic logic signed [11:0] s12(input logic [9:0] v);
    return $signed({2'b00, v});
  endfunction
  function automatic logic [11:0] mag(input logic signed [11:0] d);
    return d[11] ? 12'(-d) : 12'(d);
  endfunction
  function automatic logic rng(input logic [11:0] v, input int lo, input int hi);
    return v >= 12'(lo) && v <= 12'(hi);
  endfunction
  state_t state;
  logic [CW-1:0] cnt, cnt_nx;
  logic [BW-1:0] bcnt;
  logic blink_on, vs_q, vs_act, tick, in_zone;
  logic [9:0] s_ax, s_ay, s_bx0, s_bx1, s_by0, s_by1;
  logic s_det;
  logic signed [11:0] dx, dy, ux, uy, icx, icy;
  logic [11:0] rx, ry, ex, ey;
  logic [6:0] sq;
  logic in_ui, hit_icon, hit_ret, hit_aim, hit_box;
  logic de1, hs1, vs1, ov1, f_icon, f_ui, f_ret, f_aim, f_box;
  logic [11:0] img1, rgb_q, ui_col, mix;
  assign vs_act = vsync_in ^ INACT;
  assign tick = vs_act & ~vs_q;
  assign cnt_nx = cnt + 1'b1;
  assign in_zone = aim_detected && mag(s12(aim_x) - 12'(CX)) < 12'(LOCK_ZONE)
                   && mag(s12(aim_y) - 12'(CY)) < 12'(LOCK_ZONE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH;
      cnt <= '0;
      bcnt <= '0;
      blink_on <= 1'b1;
      vs_q <= 1'b0;
      {s_ax, s_ay, s_bx0, s_bx1, s_by0, s_by1} <= '0;
      s_det <= 1'b0;
    end else begin
      vs_q <= vs_act;
      if (tick) begin
        {s_ax, s_ay, s_det} <= {aim_x, aim_y, aim_detected};
        {s_bx0, s_bx1, s_by0, s_by1} <= {box_x_min, box_x_max, box_y_min, box_y_max};
        case (state)
          SEARCH: if (in_zone) begin
            state <= LOCK_FRAMES == 1 ? LOCKED : ACQUIRE;
            cnt <= CW'(1);
          end
          ACQUIRE: if (!in_zone) state <= SEARCH;
            else if (cnt_nx == CW'(LOCK_FRAMES)) state <= LOCKED;
            else cnt <= cnt_nx;
          LOCKED: if (!in_zone) begin
            state <= UNLOCK_FRAMES == 1 ? SEARCH : HOLD;
            cnt <= CW'(1);
          end
          HOLD: if (in_zone) state <= LOCKED;
            else if (cnt_nx == CW'(UNLOCK_FRAMES)) state <= SEARCH;
            else cnt <= cnt_nx;
        endcase
        // blink phase restarts "on" whenever HOLD is entered
        if (state == LOCKED && !in_zone && UNLOCK_FRAMES != 1) begin
          bcnt <= '0;
          blink_on <= 1'b1;
        end else if (bcnt == BW'(BLINK_FRAMES - 1)) begin
          bcnt <= '0;
          blink_on <= ~blink_on;
        end else bcnt <= bcnt + 1'b1;
      end
    end
  end
  assign locked = state[1];
  assign lock_state = state;
  assign dx = s12(x_pixel) - 12'(CX);
  assign dy = s12(y_pixel) - 12'(CY);
  assign rx = mag(dx);
  assign ry = mag(dy);
  assign sq = 7'(rx[2:0]) * 7'(rx[2:0]) + 7'(ry[2:0]) * 7'(ry[2:0]);
  assign ex = mag(s12(x_pixel) - s12(s_ax));
  assign ey = mag(s12(y_pixel) - s12(s_ay));
  assign ux = s12(x_pixel) - 12'(UI_X);
  assign uy = s12(y_pixel) - 12'(UI_Y);
  assign icx = ux - 12'sd7;
  assign icy = uy - 12'sd7;
  assign in_ui = !ux[11] && ux < 12'sd30 && !uy[11] && uy < 12'sd30;
  assign hit_icon = in_ui && !icx[11] && icx < 12'sd16 && !icy[11] && icy < 12'sd16
                    && ICON[{~icy[3:1], ~icx[3:1]}];
  assign hit_ret = (rx <= 12'd6 && ry <= 12'd6 && sq <= 7'd36)
                   || (rng(rx, 12, 22) && (dy == 12'sd0 || dy == -12'sd1))
                   || (rng(ry, 12, 22) && (dx == 12'sd0 || dx == -12'sd1))
                   || (rng(rx, 33, 35) && rng(ry, 20, 35))
                   || (rng(ry, 33, 35) && rng(rx, 20, 35));
  assign hit_aim = s_det && ((ey <= 12'(THK) && ex <= 12'(LEN)) || (ex <= 12'(THK) && ey <= 12'(LEN)));
  assign hit_box = s_det && ((((x_pixel == s_bx0) || (x_pixel == s_bx1)) && y_pixel >= s_by0 && y_pixel <= s_by1)
                   || (((y_pixel == s_by0) || (y_pixel == s_by1)) && x_pixel >= s_bx0 && x_pixel <= s_bx1));
  assign ui_col = (state == LOCKED || (state == HOLD && blink_on)) ? 12'hFF0 : 12'hFFF;
  assign mix = !de1 ? 12'h000 : !ov1 ? img1 : f_icon ? 12'h000 : f_ui ? ui_col
             : f_ret ? 12'h000 : f_aim ? 12'hF00 : f_box ? 12'h0F0 : img1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {de1, ov1, f_icon, f_ui, f_ret, f_aim, f_box} <= '0;
      {hs1, vs1} <= {INACT, INACT};
      img1 <= '0;
      rgb_q <= '0;
      de_out <= 1'b0;
      {hsync_out, vsync_out} <= {INACT, INACT};
    end else begin
      {de1, hs1, vs1, ov1, img1} <= {de_in, hsync_in, vsync_in, overlay_en, img_bg};
      {f_icon, f_ui, f_ret, f_aim, f_box} <= {hit_icon, in_ui, hit_ret, hit_aim, hit_box};
      rgb_q <= mix;
      {de_out, hsync_out, vsync_out} <= {de1, hs1, vs1};
    end
  end
  assign {r_port, g_port, b_port} = rgb_q;
endmodule
